// File: rtl/cpu_pkg.sv
// Shared writeback types: register data/index widths and the queued result record.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package cpu_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 3;

  // One completed result waiting for the register file write port.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// In-order FIFO of writeback entries; two ordered pushes and one pop per cycle.
// Latency: a pushed entry is visible at head/count on the next cycle.
// Backpressure: none internally; the owner keeps net growth within DEPTH.
module wb_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            push_valid,
  input  wb_entry_t             push0,
  input  wb_entry_t             push1,
  input  logic                  pop,
  input  logic [REG_ADDR_W-1:0] query_reg,
  output logic [CNT_W-1:0]      count,
  output wb_entry_t             head,
  output logic [DEPTH-1:0]      match
);

  wb_entry_t        entries   [DEPTH];
  wb_entry_t        entries_n [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] count_n;

  // Shift out the head on pop, then append pushes after the surviving entries.
  // push_valid[1] is only ever set together with push_valid[0].
  always_comb begin
    entries_n = entries;
    base      = count_q;
    if (pop && count_q != '0) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        entries_n[i] = entries[i+1];
      end
      base = count_q - 1'b1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (push_valid[0] && i == int'(base)) begin
        entries_n[i] = push0;
      end
      if (push_valid[1] && i == int'(base) + 1) begin
        entries_n[i] = push1;
      end
    end
    count_n = base + CNT_W'(push_valid[0]) + CNT_W'(push_valid[1]);
  end

  // Storage and occupancy; only occupancy needs clearing since count gates every entry.
  always_ff @(posedge clock) begin
    entries <= entries_n;
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_n;
    end
  end

  // Per-entry destination match for the decode hazard query.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = (i < int'(count_q)) && (entries[i].dest == query_reg);
    end
  end

  assign count = count_q;
  assign head  = entries[0];

endmodule

// File: rtl/writeback_arbiter.sv
// Serialises ALU and load results onto the single register file write port in arrival order.
// Latency: 1 cycle from acceptance with an empty queue, plus 1 cycle per entry queued ahead.
// Backpressure: both readies drop together when the queue is full; held inputs are taken after a drain.
module writeback_arbiter
  import cpu_pkg::*;
#(
  // Data and index widths must equal the cpu_pkg values, which fix the queue entry layout.
  parameter int DATA_W      = cpu_pkg::DATA_W,
  parameter int REG_ADDR_W  = cpu_pkg::REG_ADDR_W,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               alu_valid,
  input  logic [REG_ADDR_W-1:0]              alu_dest,
  input  logic [DATA_W-1:0]                  alu_data,
  output logic                               alu_ready,
  input  logic                               mem_valid,
  input  logic [REG_ADDR_W-1:0]              mem_dest,
  input  logic [DATA_W-1:0]                  mem_data,
  output logic                               mem_ready,
  input  logic [REG_ADDR_W-1:0]              query_reg,
  output logic                               query_pending,
  output logic                               regWrite,
  output logic [REG_ADDR_W-1:0]              writeRegister,
  output logic [DATA_W-1:0]                  writeData,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   pending_count
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  logic [CNT_W-1:0]       count;
  logic [QUEUE_DEPTH-1:0] match;
  wb_entry_t              head;
  wb_entry_t              mem_e;
  wb_entry_t              alu_e;
  wb_entry_t              issue_e;
  wb_entry_t              push0;
  wb_entry_t              push1;
  logic [1:0]             push_valid;
  logic                   issue_vld;
  logic                   pop;
  logic                   mem_acc;
  logic                   alu_acc;
  logic                   ready;

  // Readies depend on occupancy only; net growth is at most one per cycle so a free slot suffices.
  assign ready     = int'(count) < QUEUE_DEPTH;
  assign alu_ready = ready;
  assign mem_ready = ready;
  assign mem_acc   = mem_valid && ready;
  assign alu_acc   = alu_valid && ready;

  assign mem_e = '{dest: mem_dest, data: mem_data};
  assign alu_e = '{dest: alu_dest, data: alu_data};

  // Candidate order is queue head, then load, then ALU: the first issues, the rest queue in order.
  always_comb begin
    issue_vld  = 1'b0;
    issue_e    = head;
    pop        = 1'b0;
    push_valid = 2'b00;
    push0      = mem_e;
    push1      = alu_e;
    if (count != '0) begin
      issue_vld = 1'b1;
      pop       = 1'b1;
      if (mem_acc) begin
        push_valid[0] = 1'b1;
        push_valid[1] = alu_acc;
      end else if (alu_acc) begin
        push_valid[0] = 1'b1;
        push0         = alu_e;
      end
    end else if (mem_acc) begin
      issue_vld     = 1'b1;
      issue_e       = mem_e;
      push_valid[0] = alu_acc;
      push0         = alu_e;
    end else if (alu_acc) begin
      issue_vld = 1'b1;
      issue_e   = alu_e;
    end
  end

  wb_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clock      (clock),
    .reset      (reset),
    .push_valid (push_valid),
    .push0      (push0),
    .push1      (push1),
    .pop        (pop),
    .query_reg  (query_reg),
    .count      (count),
    .head       (head),
    .match      (match)
  );

  // Registered write port; index and data hold their last values on idle cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
    end else begin
      regWrite <= issue_vld;
      if (issue_vld) begin
        writeRegister <= issue_e.dest;
        writeData     <= issue_e.data;
      end
    end
  end

  // Same-cycle inputs are excluded: decode already sees those itself.
  assign query_pending = (|match) || (regWrite && writeRegister == query_reg);
  assign pending_count = count;

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Initiator side of the CPU register file's single write port: collects completed results from the ALU (single-cycle) and the data-memory load path (variable latency).
- Serialises results onto the register file's regWrite/writeRegister/writeData, at most one write per cycle, in arrival order.
- Buffers colliding results in a small in-order queue.
- Exposes a pending-write query that the decode stage uses for hazard stalls.

Parameters:
- DATA_W, 8, width of register data.
- REG_ADDR_W, 3, register index width (8 registers).
- QUEUE_DEPTH, 2, pending-result entries; legal range 2..4.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- alu_valid  input  1  ALU result present this cycle.
- alu_dest  input  REG_ADDR_W  ALU destination register.
- alu_data  input  DATA_W  ALU result.
- alu_ready  output  1  ALU result is accepted when alu_valid && alu_ready.
- mem_valid  input  1  load result present this cycle.
- mem_dest  input  REG_ADDR_W  load destination register.
- mem_data  input  DATA_W  load data.
- mem_ready  output  1  load result is accepted when mem_valid && mem_ready.
- query_reg  input  REG_ADDR_W  register index being checked by decode.
- query_pending  output  1  combinational; 1 if query_reg matches any queued entry or the write currently driven.
- regWrite  output  1  register file write enable (registered).
- writeRegister  output  REG_ADDR_W  register file write index (registered).
- writeData  output  DATA_W  register file write data (registered).
- pending_count  output  $clog2(QUEUE_DEPTH+1)  current queue occupancy.

Behaviour:
- Interface: one clock (clock); reset is synchronous, active-high (reset). On reset: queue flushed, pending_count=0, regWrite=0, writeRegister=0, writeData=0, alu_ready=1, mem_ready=1.
- Reset mid-operation: queued entries and any accepted-this-cycle inputs are discarded, never written.
- Ready generation: alu_ready = mem_ready = (pending_count < QUEUE_DEPTH). Both ready signals are combinational from occupancy only, never from valid.
- Per-cycle candidate order: queue head (oldest), then accepted mem result, then accepted ALU result.
- Issue: the first candidate is registered onto the write port, so it appears on regWrite/writeRegister/writeData the next cycle with regWrite=1.
- Enqueue: remaining candidates are enqueued, mem before ALU.
- No candidate: regWrite=0 next cycle; writeRegister and writeData hold their previous values.
- Net queue growth is at most 1 per cycle, so the ready rule cannot overflow.
- Latency: with the queue empty, a lone accepted result reaches the write port 1 cycle later. Each queued entry adds 1 cycle.
- Ordering: same-cycle mem and ALU results to the same dest are both written, mem first then ALU, so the ALU value is final. No coalescing and no dropping.
- Register 0 is written like any other index; this block applies no special casing.
- query_pending covers the queue contents plus the entry presented on the write port this cycle. It does not cover inputs arriving in the same cycle; decode already has those.
- Valid while not ready: the input is ignored, and the source must hold it until accepted.

Decomposition:
- Package cpu_pkg:
  - DATA_W and REG_ADDR_W constants.
  - typedef wb_entry_t, a packed struct {dest, data}.
- Sub-module wb_queue: parameterised in-order FIFO of wb_entry_t.
  - Push port accepts up to 2 entries per cycle (ordered); pop port removes 1.
  - Outputs count, head, and a per-entry match vector for the query.
- writeback_arbiter holds the candidate ordering, the ready logic and the output register.

Test Plan:
- After reset, alu_valid=1 dest=3 data=0x5A for 1 cycle -> next cycle regWrite=1, writeRegister=3, writeData=0x5A; following cycle regWrite=0, pending_count=0.
- Same cycle mem(dest=2,0x11) and alu(dest=4,0x22) -> cycle+1 writes r2=0x11 with pending_count=1; cycle+2 writes r4=0x22 with pending_count=0.
- Back-to-back dual issue for 3 cycles with QUEUE_DEPTH=2 -> pending_count reaches 2, both readies drop to 0, held inputs are accepted after the drain, and all 6 writes appear in order with no loss.
- Same cycle mem(dest=5,0xAA) and alu(dest=5,0xBB) -> r5 is written 0xAA, then 0xBB on the following cycle.
- Queue holding dest=6, query_reg=6 -> query_pending=1; query_reg=1 -> query_pending=0; after drain, query_reg=6 -> query_pending=0.
- Queue at 2 entries, reset asserted for 1 cycle -> next cycle regWrite=0, pending_count=0, readies=1, and the discarded entries are never written.
